// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: drives PC next/freeze, the imem request handshake and the IF/ID register.
// Optional FETCH_PERF_EN macro enables the freeze-cycle counter on stall_cycles.
module fetch_sequencer #(
  parameter int unsigned INSTR_BYTES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] next_address,
  output logic        freeze,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        hazard,
  input  logic        branch_taken,
  input  logic [31:0] branch_address,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] stall_cycles
);

  typedef enum logic {REQ, HOLD} state_t;

  state_t      state;
  logic        redir_pend;
  logic [31:0] redir_addr;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc;
  logic [31:0] seq_address;

  assign seq_address = pc + 32'(INSTR_BYTES);
  assign imem_addr   = pc;
  assign imem_req    = (state == REQ);

  // PC steering; anything not explicitly advancing keeps the PC frozen.
  always_comb begin
    freeze       = 1'b1;
    next_address = pc;
    if (!reset) begin
      case (state)
        REQ: begin
          if (imem_ready) begin
            if (branch_taken) begin
              freeze       = 1'b0;
              next_address = branch_address;
            end else if (redir_pend) begin
              freeze       = 1'b0;
              next_address = redir_addr;
            end else if (!hazard) begin
              freeze       = 1'b0;
              next_address = seq_address;
            end
          end
        end
        HOLD: begin
          if (branch_taken) begin
            freeze       = 1'b0;
            next_address = branch_address;
          end else if (!hazard) begin
            freeze       = 1'b0;
            next_address = seq_address;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= REQ;
      redir_pend <= 1'b0;
      redir_addr <= '0;
      buf_instr  <= '0;
      buf_pc     <= '0;
      if_valid   <= 1'b0;
      if_instr   <= '0;
      if_pc      <= '0;
    end else begin
      // A redirect always empties IF/ID, even if ID is stalled.
      if (branch_taken)
        if_valid <= 1'b0;
      case (state)
        REQ: begin
          if (!imem_ready) begin
            // Request stays up; remember the newest target until the response returns.
            if (branch_taken) begin
              redir_pend <= 1'b1;
              redir_addr <= branch_address;
            end
          end else if (branch_taken || redir_pend) begin
            redir_pend <= 1'b0;
          end else if (!hazard) begin
            if_valid <= 1'b1;
            if_instr <= imem_rdata;
            if_pc    <= pc;
          end else begin
            buf_instr <= imem_rdata;
            buf_pc    <= pc;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (branch_taken) begin
            buf_instr <= '0;
            buf_pc    <= '0;
            state     <= REQ;
          end else if (!hazard) begin
            if_valid <= 1'b1;
            if_instr <= buf_instr;
            if_pc    <= buf_pc;
            state    <= REQ;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] stall_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_count <= '0;
    else if (freeze)
      stall_count <= stall_count + 32'd1;
  end

  assign stall_cycles = stall_count;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a PC register and a word-per-address memory model around the DUT.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] next_address;
  logic        freeze;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        hazard;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] stall_cycles;

  logic        pc_load;
  logic [31:0] pc_load_val;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.INSTR_BYTES(4)) dut (
    .clk(clk), .reset(reset), .pc(pc), .next_address(next_address), .freeze(freeze),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .hazard(hazard), .branch_taken(branch_taken), .branch_address(branch_address),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .stall_cycles(stall_cycles)
  );

  // PC register obeying freeze, with a bench-only load path for the wrap test.
  always @(posedge clk or posedge reset) begin
    if (reset)           pc <= 32'd0;
    else if (pc_load)    pc <= pc_load_val;
    else if (!freeze)    pc <= next_address;
  end

  assign imem_rdata = imem_ready ? (32'hC0DE0000 ^ pc) : 32'hDEADBEEF;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_ready = 1'b0; hazard = 1'b0; branch_taken = 1'b0;
    branch_address = 32'd0; pc_load = 1'b0; pc_load_val = 32'd0;
    tick(); tick();
    checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL reset_freeze: got %b want 1", freeze); end
    checks++; if (next_address !== 32'd0) begin errors++; $display("FAIL reset_next: got %h want 0", next_address); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if_valid); end
    checks++; if (if_instr !== 32'd0 || if_pc !== 32'd0) begin errors++; $display("FAIL reset_ifid: got %h/%h want 0/0", if_instr, if_pc); end
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", stall_cycles); end
    reset = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_req: got %b want 1", imem_req); end
    $display("test_reset done");
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    imem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_pc = 32'(i * 4);
      #1;
      checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL seq_freeze[%0d]: got %b want 0", i, freeze); end
      checks++; if (next_address !== exp_pc + 32'd4) begin errors++; $display("FAIL seq_next[%0d]: got %h want %h", i, next_address, exp_pc + 32'd4); end
      tick();
      checks++; if (if_valid !== 1'b1 || if_pc !== exp_pc || if_instr !== (32'hC0DE0000 ^ exp_pc))
        begin errors++; $display("FAIL seq_load[%0d]: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", i, if_valid, if_pc, if_instr, exp_pc, 32'hC0DE0000 ^ exp_pc); end
      $display("seq fetch pc=%h instr=%h", if_pc, if_instr);
    end
  endtask

  task automatic test_wait();
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (freeze !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h10)
        begin errors++; $display("FAIL wait[%0d]: got frz=%b req=%b addr=%h want 1/1/00000010", i, freeze, imem_req, imem_addr); end
      tick();
      checks++; if (if_pc !== 32'hC) begin errors++; $display("FAIL wait_hold[%0d]: got if_pc %h want c", i, if_pc); end
    end
    imem_ready = 1'b1;
    #1;
    checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL wait_ready_freeze: got %b want 0", freeze); end
    tick();
    imem_ready = 1'b0;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h10 || if_instr !== 32'hC0DE0010)
      begin errors++; $display("FAIL wait_load: got v=%b pc=%h ins=%h want 1/10/c0de0010", if_valid, if_pc, if_instr); end
    $display("wait fetch pc=%h instr=%h", if_pc, if_instr);
  endtask

  task automatic test_hazard();
    imem_ready = 1'b1; hazard = 1'b1;
    #1;
    checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL haz_freeze0: got %b want 1", freeze); end
    tick();
    imem_ready = 1'b0;
    checks++; if (imem_req !== 1'b0 || if_pc !== 32'h10) begin errors++; $display("FAIL haz_hold: got req=%b if_pc=%h want 0/10", imem_req, if_pc); end
    #1;
    checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL haz_freeze1: got %b want 1", freeze); end
    tick();
    hazard = 1'b0;
    #1;
    checks++; if (freeze !== 1'b0 || next_address !== 32'h18) begin errors++; $display("FAIL haz_release: got frz=%b next=%h want 0/18", freeze, next_address); end
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h14 || if_instr !== 32'hC0DE0014 || imem_req !== 1'b1)
      begin errors++; $display("FAIL haz_load: got v=%b pc=%h ins=%h req=%b want 1/14/c0de0014/1", if_valid, if_pc, if_instr, imem_req); end
    $display("hazard fetch pc=%h instr=%h", if_pc, if_instr);
  endtask

  task automatic test_branch_outstanding();
    imem_ready = 1'b1;
    tick(); tick();
    checks++; if (pc !== 32'h20) begin errors++; $display("FAIL br_setup: got pc %h want 20", pc); end
    imem_ready = 1'b0; branch_taken = 1'b1; branch_address = 32'h100;
    #1;
    checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL br_pend_freeze: got %b want 1", freeze); end
    tick();
    branch_taken = 1'b0; branch_address = 32'h0;
    checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL br_flush: got v=%b req=%b want 0/1", if_valid, imem_req); end
    tick();
    imem_ready = 1'b1;
    #1;
    checks++; if (freeze !== 1'b0 || next_address !== 32'h100) begin errors++; $display("FAIL br_redirect: got frz=%b next=%h want 0/100", freeze, next_address); end
    tick();
    checks++; if (if_valid !== 1'b0 || pc !== 32'h100) begin errors++; $display("FAIL br_drop: got v=%b pc=%h want 0/100", if_valid, pc); end
    tick();
    imem_ready = 1'b0;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== 32'hC0DE0100)
      begin errors++; $display("FAIL br_target: got v=%b pc=%h ins=%h want 1/100/c0de0100", if_valid, if_pc, if_instr); end
    $display("branch fetch pc=%h instr=%h", if_pc, if_instr);
  endtask

  task automatic test_hold_branch();
    imem_ready = 1'b1; hazard = 1'b1;
    tick();
    imem_ready = 1'b0;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hb_hold: got req=%b want 0", imem_req); end
    branch_taken = 1'b1; branch_address = 32'h200;
    #1;
    checks++; if (freeze !== 1'b0 || next_address !== 32'h200) begin errors++; $display("FAIL hb_next: got frz=%b next=%h want 0/200", freeze, next_address); end
    tick();
    branch_taken = 1'b0; hazard = 1'b0;
    checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200)
      begin errors++; $display("FAIL hb_flush: got v=%b req=%b addr=%h want 0/1/200", if_valid, imem_req, imem_addr); end
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h200) begin errors++; $display("FAIL hb_target: got v=%b pc=%h want 1/200", if_valid, if_pc); end
    $display("hold-branch fetch pc=%h instr=%h", if_pc, if_instr);
  endtask

  task automatic test_wrap();
    pc_load = 1'b1; pc_load_val = 32'hFFFFFFFC;
    tick();
    pc_load = 1'b0; imem_ready = 1'b1;
    #1;
    checks++; if (next_address !== 32'd0) begin errors++; $display("FAIL wrap_next: got %h want 0", next_address); end
    tick();
    imem_ready = 1'b0;
    checks++; if (if_pc !== 32'hFFFFFFFC || pc !== 32'd0) begin errors++; $display("FAIL wrap_load: got if_pc=%h pc=%h want fffffffc/0", if_pc, pc); end
    $display("wrap fetch pc=%h instr=%h", if_pc, if_instr);
  endtask

  task automatic test_perf();
    logic [31:0] exp_count;
    reset = 1'b1;
    tick();
    reset = 1'b0; imem_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
`ifdef FETCH_PERF_EN
    exp_count = 32'd5;
`else
    exp_count = 32'd0;
`endif
    checks++; if (stall_cycles !== exp_count) begin errors++; $display("FAIL perf_count: got %0d want %0d", stall_cycles, exp_count); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (stall_cycles !== 32'd0 || if_valid !== 1'b0) begin errors++; $display("FAIL perf_reset: got cnt=%0d v=%b want 0/0", stall_cycles, if_valid); end
    $display("perf stall_cycles=%0d", exp_count);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait();
    test_hazard();
    test_branch_outstanding();
    test_hold_branch();
    test_wrap();
    test_perf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
